// File: rtl/sb_tx_pkg.sv
// -----------------------------------------------------------------------------
// sb_tx_pkg
//   Shared types and constants for the sideband transmit serializer.
//   - sb_tx_state_e : serializer FSM state (IDLE / SHIFT / GAP)
//   - SB_PKT_UI     : UI per sideband packet (default packet width)
//   - SB_GAP_UI     : mandatory idle UI after each packet
//   - sb_max        : helper used to size the shared SHIFT/GAP counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package sb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_tx_state_e;

    localparam int SB_PKT_UI = 64;
    localparam int SB_GAP_UI = 32;

    function automatic int sb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : sb_tx_pkg

// File: rtl/sb_tx_serializer.sv
// -----------------------------------------------------------------------------
// sb_tx_serializer
//   Accepts one DATA_W-bit sideband packet over a valid/ready handshake and
//   shifts it out LSB-first on TXDATASB, one bit per pll_clk cycle. clk_en
//   gates the sideband clock controller so TXCKSB toggles only while data
//   bits are on the lane. Each packet is followed by GAP_UI idle UI with
//   data and clock enable both low.
//
// Ports
//   pll_clk     in   sideband bit clock, rising-edge logic
//   rst_n       in   asynchronous active-low reset
//   tx_data_in  in   packet to send, bit 0 transmitted first
//   tx_valid    in   tx_data_in holds a packet
//   tx_ready    out  serializer accepts a packet this cycle (state == IDLE)
//   TXDATASB    out  serial sideband data lane (registered)
//   clk_en      out  clock-controller enable (registered)
//   tx_busy     out  a packet or its idle gap is in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sb_tx_serializer
    import sb_tx_pkg::*;
#(
    parameter int DATA_W = SB_PKT_UI,
    parameter int GAP_UI = SB_GAP_UI
) (
    input  logic              pll_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              TXDATASB,
    output logic              clk_en,
    output logic              tx_busy
);

    // One counter serves both the SHIFT and the GAP phase.
    localparam int CNT_W = sb_max(sb_max($clog2(DATA_W), $clog2(GAP_UI)), 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_UI - 1);

    sb_tx_state_e      state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              txd_q;
    logic              clk_en_q;

    // Bit 0 is launched into txd_q on the handshake edge, so shreg_q holds the
    // packet already shifted by one: its bit 0 is always the next bit to send.
    // This keeps the pins flop-driven while bit 0 still appears one cycle
    // after the handshake.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            txd_q    <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shreg_q  <= {1'b0, tx_data_in[DATA_W-1:1]};
                        txd_q    <= tx_data_in[0];
                        clk_en_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cnt_q == SHIFT_LAST) begin
                        // Last bit has been on the lane for its UI: data and
                        // clock enable drop together for the idle gap.
                        txd_q    <= 1'b0;
                        clk_en_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= GAP;
                    end else begin
                        txd_q    <= shreg_q[0];
                        shreg_q  <= {1'b0, shreg_q[DATA_W-1:1]};
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    txd_q    <= 1'b0;
                    clk_en_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);
    assign TXDATASB = txd_q;
    assign clk_en   = clk_en_q;

endmodule : sb_tx_serializer

// File: tb/tb_sb_tx_serializer.sv
`timescale 1ns/1ps

module tb_sb_tx_serializer;

    localparam int DATA_W = 64;
    localparam int GAP_UI = 32;
    // Handshake-to-handshake minimum distance: packet UI + gap UI + IDLE cycle.
    localparam int PERIOD = DATA_W + GAP_UI + 1;

    logic              pll_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic [DATA_W-1:0] tx_data_in = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              TXDATASB;
    logic              clk_en;
    logic              tx_busy;

    sb_tx_serializer #(
        .DATA_W (DATA_W),
        .GAP_UI (GAP_UI)
    ) dut (
        .pll_clk    (pll_clk),
        .rst_n      (rst_n),
        .tx_data_in (tx_data_in),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TXDATASB   (TXDATASB),
        .clk_en     (clk_en),
        .tx_busy    (tx_busy)
    );

    always #5 pll_clk = ~pll_clk;

    // Cycle number: value of cyc after the rising edge that starts the cycle.
    int cyc = 0;
    always @(posedge pll_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: the serializer can take a packet in cycle c when
    // c >= next_ok; an accepted packet in cycle T occupies the lane from T+1.
    int next_ok = 0;
    bit exp_bits[$];
    int exp_start[$];
    int run_len = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no expected entry available (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge pll_clk);
        #1;
    endtask

    // Drive one cycle of inputs; the model decides whether this is a handshake.
    task automatic drive_cycle(input bit v, input logic [DATA_W-1:0] d, output bit acc);
        tx_valid   = v;
        tx_data_in = d;
        step();
        acc = 1'b0;
        if (v && rst_n && (cyc - 1) >= next_ok) begin
            acc     = 1'b1;
            next_ok = (cyc - 1) + PERIOD;
            exp_start.push_back(cyc);
            for (int i = 0; i < DATA_W; i++) exp_bits.push_back(d[i]);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, acc);
    endtask

    // Holds tx_valid with the packet until it is taken; valid stays high.
    task automatic send(input logic [DATA_W-1:0] d);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 3 * PERIOD) begin
            drive_cycle(1'b1, d, acc);
            n++;
        end
        if (!acc) fail_now("send_timeout");
    endtask

    // Monitor / scoreboard
    always @(negedge pll_clk) begin
        if (!rst_n) begin
            check("rst_txdata", longint'(TXDATASB), 0);
            check("rst_clk_en", longint'(clk_en), 0);
            check("rst_busy",   longint'(tx_busy), 0);
            check("rst_ready",  longint'(tx_ready), 1);
            run_len = 0;
        end else begin
            bit exp_rdy;
            exp_rdy = (cyc >= next_ok);
            check("tx_ready", longint'(tx_ready), longint'(exp_rdy));
            check("tx_busy",  longint'(tx_busy),  longint'(!exp_rdy));
            if (clk_en) begin
                if (run_len == 0) begin
                    if (exp_start.size() == 0) fail_now("window_start");
                    else check("window_start", cyc, exp_start.pop_front());
                end
                run_len++;
                if (exp_bits.size() == 0) fail_now("txdata_bit");
                else check("txdata_bit", longint'(TXDATASB), longint'(exp_bits.pop_front()));
            end else begin
                check("gap_data_low", longint'(TXDATASB), 0);
                if (run_len != 0) begin
                    check("window_len", run_len, DATA_W);
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [DATA_W-1:0] d;

        // Reset held for 10 cycles
        repeat (10) @(posedge pll_clk);
        @(negedge pll_clk);
        rst_n = 1'b1;
        step();
        idle(3);

        // Single packet
        send(64'hA5A5_0000_FFFF_1234);
        tx_valid = 1'b0;
        idle(PERIOD + 2);

        // Back-to-back with tx_valid held
        send(64'h1);
        send(64'h8000_0000_0000_0000);
        tx_valid = 1'b0;
        idle(PERIOD + 2);

        // Pulses while busy are ignored
        send(64'hFFFF_0000_1234_5678);
        idle(9);
        drive_cycle(1'b1, 64'hDEAD_BEEF, acc);
        idle(69);
        drive_cycle(1'b1, 64'hDEAD_BEEF, acc);
        idle(PERIOD);

        // Reset mid-shift drops the packet in flight
        send(64'hCAFE_F00D_0BAD_BEEF);
        idle(29);
        #2;
        check("pre_reset_clk_en", longint'(clk_en), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_txdata", longint'(TXDATASB), 0);
        check("async_rst_clk_en", longint'(clk_en), 0);
        check("async_rst_ready",  longint'(tx_ready), 1);
        exp_bits.delete();
        exp_start.delete();
        next_ok = 0;
        repeat (3) @(negedge pll_clk);
        rst_n = 1'b1;
        step();
        send(64'h0F);
        tx_valid = 1'b0;
        idle(PERIOD + 2);

        // Randomized traffic with noise on tx_valid while busy
        for (int p = 0; p < 20; p++) begin
            d = {$urandom, $urandom};
            send(d);
            while (cyc < next_ok) begin
                drive_cycle($urandom_range(0, 3) == 0, {$urandom, $urandom}, acc);
            end
            tx_valid = 1'b0;
            idle($urandom_range(0, 3));
        end
        tx_valid = 1'b0;
        idle(PERIOD + 5);

        check("leftover_bits",    exp_bits.size(), 0);
        check("leftover_windows", exp_start.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sb_tx_serializer

// File: doc/sb_tx_serializer.md
# sb_tx_serializer

Sideband transmit serializer: accepts one 64-bit sideband packet over a valid/ready handshake and shifts it out LSB-first on the sideband data lane, one bit per `pll_clk` cycle. It drives the `enable` input of `SB_CLOCK_CONTROLLER` so that `TXCKSB` toggles only while data bits are on the lane. After each packet it enforces the mandatory 32-UI idle gap, with clock and data both held low. It sits between the sideband packet formatter and the clock controller, in the 800 MHz `pll_clk` domain.

## Interface

Parameters:
- `DATA_W`, default 64: packet width in bits (UI per packet).
- `GAP_UI`, default 32: idle UI enforced after each packet.

Ports:
- `pll_clk`  in  1: 800 MHz sideband bit clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tx_data_in`  in  DATA_W: packet to send; bit 0 is transmitted first.
- `tx_valid`  in  1: `tx_data_in` holds a packet.
- `tx_ready`  out  1: the serializer can accept a packet this cycle.
- `TXDATASB`  out  1: serial sideband data lane.
- `clk_en`  out  1: gate enable; connects to the `SB_CLOCK_CONTROLLER` `enable` input.
- `tx_busy`  out  1: a packet or its gap is in progress.

## Operation

- FSM states are `IDLE`, `SHIFT` and `GAP`.
- **`IDLE`**
  - `tx_ready` = 1. This is combinational: `state == IDLE`.
  - On `tx_valid && tx_ready`:
    - load `tx_data_in` into a `DATA_W` shift register;
    - clear the bit counter;
    - go to `SHIFT`.
  - `tx_valid` without the handshake changes nothing.
- **`SHIFT`**
  - `tx_ready` = 0 and `clk_en` = 1.
  - `TXDATASB` = `shreg[0]`; the register shifts right each cycle and fills with 0.
  - The counter (`$clog2(DATA_W)` bits) increments each cycle.
  - When count = `DATA_W`-1, go to `GAP` and clear the counter.
- **`GAP`**
  - `TXDATASB` = 0, `clk_en` = 0, `tx_ready` = 0.
  - The counter (`$clog2(GAP_UI)` bits) increments.
  - When count = `GAP_UI`-1, go to `IDLE`.
- `tx_busy` = `(state != IDLE)`.
- `TXDATASB` and `clk_en` come straight from flops, with no combinational path to the pins. Both are updated in the same cycle, so the data and the clock gate stay aligned.
- `tx_valid` is ignored while busy. The upstream block must hold the packet until `tx_ready`.
- Counters never wrap past their terminal value; the state change happens on the terminal count.

## Timing

- Reset values: `TXDATASB` = 0, `clk_en` = 0, `tx_busy` = 0, `tx_ready` = 1 (`IDLE`), shift register = 0, counters = 0.
- Asserting `rst_n` low mid-packet or mid-gap:
  - all outputs go to their reset values immediately (asynchronously);
  - the packet in flight is dropped;
  - no resume after release.
- Handshake at cycle T:
  - bit 0 is on `TXDATASB`, with `clk_en` = 1, during cycle T+1;
  - bit k is driven during T+1+k;
  - bit 63 is driven during T+64.
- Gap occupies cycles T+65 to T+96 (32 cycles), with `TXDATASB` = 0 and `clk_en` = 0.
- `IDLE` and `tx_ready` = 1 return at T+97. The earliest next handshake is T+97, so the minimum packet period is 97 cycles.
- `clk_en` is high for exactly `DATA_W` consecutive cycles per packet.
- A `tx_valid` rising in the same cycle that `GAP` ends is not accepted. It is accepted on the following (`IDLE`) cycle.

## Structure

- Package `sb_tx_pkg` holds:
  - the state enum type `sb_tx_state_e` (`IDLE`, `SHIFT`, `GAP`);
  - the constants `SB_PKT_UI` = 64 and `SB_GAP_UI` = 32, which are used as parameter defaults.
- Single module, no sub-modules:
  - one shared counter, sized to the larger of the two widths;
  - the shift register;
  - a 3-state FSM.
- Expected size is about 150 lines.

## Test plan

- **Reset:** hold `rst_n` = 0 for 10 cycles, then release → `TXDATASB` = 0, `clk_en` = 0, `tx_busy` = 0, `tx_ready` = 1 throughout.
- **Single packet:** send `64'hA5A5_0000_FFFF_1234` at cycle T → `TXDATASB` reproduces bits 0..63 during T+1..T+64; `clk_en` is high for exactly 64 cycles; `TXDATASB` = 0 and `clk_en` = 0 during T+65..T+96; `tx_ready` = 1 at T+97.
- **Back-to-back:** hold `tx_valid` = 1 with packets `64'h1` then `64'h8000_0000_0000_0000` → second handshake at T+97; second packet's bit 63 = 1 appears at T+161; the gap between the two `clk_en` windows is exactly 33 cycles low (32 gap cycles plus the `IDLE` handshake cycle).
- **Busy ignore:** pulse `tx_valid` with `64'hDEAD_BEEF` at T+10 and T+80 → no handshake (`tx_ready` = 0); the serial output is unchanged from the first packet.
- **Reset mid-shift:** drop `rst_n` at T+30 → `TXDATASB` and `clk_en` go to 0 the same instant; after release, `tx_ready` = 1 and a new packet `64'h0F` serializes correctly from bit 0.
- **With `Clock_Divider_by_8` and `SB_CLOCK_CONTROLLER`:** connect `clk_en` to `enable` → count 64 `TXCKSB` pulses per packet and 0 pulses during each gap.
